seven_seg_count_display: RTL and testbench

//  Display side of the tenth-second count: takes the 14-bit tenths count and shows it
//  as seconds "XXX.X" on a 4-digit multiplexed 7-segment display (Alchitry Io board).

---
 rtl/seven_seg_count_display_pkg.sv | 41 ++++
 rtl/seven_seg_count_display_bin14_to_bcd.sv | 77 +++++++
 rtl/seven_seg_count_display.sv | 123 ++++++++++++
 tb/tb_seven_seg_count_display.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_count_display_pkg.sv
// Shared constants, converter state encoding and 7-segment glyph table.
package seven_seg_count_display_pkg;

  localparam int unsigned digit_count = 4;
  localparam int unsigned bin_w       = 14;
  localparam int unsigned bcd_w       = 16;
  localparam int unsigned shift_count = 14;

  localparam logic [bin_w-1:0] max_display = 14'd9999;

  // Active-high segment patterns {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] seg_off = 8'h00;
  localparam logic [7:0] seg_dp  = 8'h80;

  typedef enum logic [1:0] {
    conv_idle,
    conv_load,
    conv_shift,
    conv_done
  } conv_state_t;

  // Decimal glyphs only; codes A-F never reach the display
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] code;
    case (d)
      4'd0:    code = 8'h3F;
      4'd1:    code = 8'h06;
      4'd2:    code = 8'h5B;
      4'd3:    code = 8'h4F;
      4'd4:    code = 8'h66;
      4'd5:    code = 8'h6D;
      4'd6:    code = 8'h7D;
      4'd7:    code = 8'h07;
      4'd8:    code = 8'h7F;
      4'd9:    code = 8'h6F;
      default: code = seg_off;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seven_seg_count_display_bin14_to_bcd.sv
// Iterative double-dabble: 14-bit binary to 4-digit BCD, one shift per clk.
module seven_seg_count_display_bin14_to_bcd
  import seven_seg_count_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [bin_w-1:0] din,
  input  logic             din_ovf,
  output logic             busy,
  output logic             done,
  output logic [bcd_w-1:0] dout,
  output logic             dout_ovf
);

  conv_state_t      state;
  logic [bin_w-1:0] bin;
  logic [3:0]       iter;
  logic [bcd_w-1:0] bcd;
  logic [bcd_w-1:0] bcd_adj_c;

  assign dout = bcd;

  // Add 3 to every BCD nibble that is 5 or more before the next shift
  always_comb begin
    bcd_adj_c = bcd;
    for (int i = 0; i < int'(digit_count); i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        bcd_adj_c[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: operand latched in LOAD, result and flag presented during DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= conv_idle;
      bin      <= '0;
      bcd      <= '0;
      iter     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout_ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        conv_idle: begin
          if (start) begin
            state <= conv_load;
            busy  <= 1'b1;
          end
        end
        conv_load: begin
          bin      <= din;
          bcd      <= '0;
          iter     <= '0;
          dout_ovf <= din_ovf;
          state    <= conv_shift;
        end
        conv_shift: begin
          {bcd, bin} <= 30'({bcd_adj_c, bin, 1'b0});
          iter       <= iter + 4'd1;
          if (iter == 4'(shift_count - 1)) begin
            state <= conv_done;
            done  <= 1'b1;
          end
        end
        conv_done: begin
          state <= conv_idle;
          busy  <= 1'b0;
        end
        default: state <= conv_idle;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_count_display.sv
// Tenths-of-second count shown as "XXX.X" on a 4-digit multiplexed 7-segment display.
module seven_seg_count_display
  import seven_seg_count_display_pkg::*;
#(
  parameter int unsigned ticks_1_second = 100_000_000,
  parameter int unsigned scan_hz        = 250,
  parameter bit          active_low     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] value,
  input  logic        blank,
  output logic [7:0]  seg,
  output logic [3:0]  sel,
  output logic        overflow
);

  localparam int unsigned p     = ticks_1_second / (scan_hz * 4);
  localparam int unsigned pre_w = $clog2(p);

  localparam logic [7:0] seg_idle = active_low ? ~seg_off : seg_off;
  localparam logic [3:0] sel_idle = active_low ? 4'hF : 4'h0;

  // A digit period shorter than a full conversion would let triggers collide
  generate
    if (p < 17) begin : g_bad_period
      $error("seven_seg_count_display: digit period must be at least 17 clk");
    end
  endgenerate

  logic [pre_w-1:0] pre;
  logic [1:0]       idx;
  logic [15:0]      disp;
  logic             trigger_c;
  logic [13:0]      operand_c;
  logic             ovf_c;
  logic             conv_busy;
  logic             conv_done;
  logic [15:0]      conv_dout;
  logic             conv_ovf;
  logic [3:0]       nib_c;
  logic             lit_c;
  logic [7:0]       pat_c;
  logic [3:0]       onehot_c;

  assign trigger_c = (pre == pre_w'(p - 1)) && (idx == 2'd3);
  assign ovf_c     = (value > max_display);
  assign operand_c = ovf_c ? max_display : value;

  // Digit prescaler and scan index; index wrap 3->0 starts a new frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == pre_w'(p - 1)) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + pre_w'(1);
    end
  end

  seven_seg_count_display_bin14_to_bcd u_conv (
    .clk      (clk),
    .rst      (rst),
    .start    (trigger_c && !conv_busy),
    .din      (operand_c),
    .din_ovf  (ovf_c),
    .busy     (conv_busy),
    .done     (conv_done),
    .dout     (conv_dout),
    .dout_ovf (conv_ovf)
  );

  // Display digits and overflow flag update together when a conversion completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp     <= '0;
      overflow <= 1'b0;
    end else if (conv_done) begin
      disp     <= conv_dout;
      overflow <= conv_ovf;
    end
  end

  // Select the current digit, apply leading-zero blanking and the decimal point
  always_comb begin
    nib_c    = disp[3:0];
    lit_c    = 1'b1;
    onehot_c = 4'b0001 << idx;
    case (idx)
      2'd0: nib_c = disp[3:0];
      2'd1: nib_c = disp[7:4];
      2'd2: begin
        nib_c = disp[11:8];
        lit_c = (disp[15:8] != 8'd0);
      end
      default: begin
        nib_c = disp[15:12];
        lit_c = (disp[15:12] != 4'd0);
      end
    endcase
    pat_c = lit_c ? seg_code(nib_c) : seg_off;
    if (idx == 2'd1) begin
      pat_c = pat_c | seg_dp;
    end
  end

  // Pin registers with polarity; blank darkens everything without stopping the scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= seg_idle;
      sel <= sel_idle;
    end else if (blank) begin
      seg <= seg_idle;
      sel <= sel_idle;
    end else begin
      seg <= active_low ? ~pat_c : pat_c;
      sel <= active_low ? ~onehot_c : onehot_c;
    end
  end

endmodule

// File: tb/tb_seven_seg_count_display.sv
// Directed bench for seven_seg_count_display with a 10-clk digit period.
module tb_seven_seg_count_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] value;
  logic        blank;
  logic [7:0]  seg;
  logic [3:0]  sel;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int cyc;

  seven_seg_count_display #(
    .ticks_1_second (400),
    .scan_hz        (10),
    .active_low     (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .blank    (blank),
    .seg      (seg),
    .sel      (sel),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; frame k triggers at cyc 40k, new digits visible from 40k+17
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Record one full frame of a stable display snapshot as {d3,d2,d1,d0}
  task automatic capture(output logic [31:0] segs, output logic ovf, output logic ok);
    int guard = 0;
    segs = '0;
    ovf  = 1'bx;
    while ((cyc % 40) != 17 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    ok  = (guard < 200);
    ovf = overflow;
    for (int i = 0; i < 40; i++) begin
      case (sel)
        4'hE: segs[7:0]   = seg;
        4'hD: segs[15:8]  = seg;
        4'hB: segs[23:16] = seg;
        4'h7: segs[31:24] = seg;
        default: ;
      endcase
      @(negedge clk);
    end
  endtask

  task automatic apply_and_capture(input logic [13:0] v, output logic [31:0] segs,
                                   output logic ovf, output logic ok);
    value = v;
    repeat (41) @(negedge clk);
    capture(segs, ovf, ok);
  endtask

  task automatic test_reset;
    logic [31:0] segs;
    logic        ovf;
    logic        ok;
    rst = 1'b1; value = 14'd1234; blank = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (seg !== 8'hFF) begin failures++; $display("FAIL reset_seg: got %h expected ff", seg); end
    if (sel !== 4'hF) begin failures++; $display("FAIL reset_sel: got %h expected f", sel); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    rst = 1'b0;
    for (int k = 1; k <= 57; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          checks += 2;
          if (sel !== 4'hE) begin failures++; $display("FAIL first_sel: got %h expected e", sel); end
          if (seg !== 8'hC0) begin failures++; $display("FAIL first_seg: got %h expected c0", seg); end
        end
        10: begin
          checks++;
          if (sel !== 4'hE) begin failures++; $display("FAIL scan_latency: got %h expected e", sel); end
        end
        11: begin
          checks += 2;
          if (sel !== 4'hD) begin failures++; $display("FAIL scan_d1_sel: got %h expected d", sel); end
          if (seg !== 8'h40) begin failures++; $display("FAIL zero_d1_seg: got %h expected 40", seg); end
        end
        21: begin
          checks += 2;
          if (sel !== 4'hB) begin failures++; $display("FAIL scan_d2_sel: got %h expected b", sel); end
          if (seg !== 8'hFF) begin failures++; $display("FAIL zero_d2_blank: got %h expected ff", seg); end
        end
        31: begin
          checks += 2;
          if (sel !== 4'h7) begin failures++; $display("FAIL scan_d3_sel: got %h expected 7", sel); end
          if (seg !== 8'hFF) begin failures++; $display("FAIL zero_d3_blank: got %h expected ff", seg); end
        end
        41: begin
          checks++;
          if (sel !== 4'hE) begin failures++; $display("FAIL scan_wrap_sel: got %h expected e", sel); end
        end
        56: begin
          checks++;
          if (seg !== 8'h40) begin failures++; $display("FAIL conv_latency_early: got %h expected 40", seg); end
        end
        57: begin
          checks++;
          if (seg !== 8'h30) begin failures++; $display("FAIL conv_latency: got %h expected 30", seg); end
        end
        default: ;
      endcase
    end
    capture(segs, ovf, ok);
    checks += 3;
    if (!ok) begin failures++; $display("FAIL v1234_timeout: frame alignment not found"); end
    if (segs !== 32'hF9A43099) begin failures++; $display("FAIL v1234_digits: got %h expected f9a43099", segs); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL v1234_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_small_values;
    logic [31:0] segs;
    logic        ovf;
    logic        ok;
    apply_and_capture(14'd7, segs, ovf, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL v7_timeout: frame alignment not found"); end
    if (segs !== 32'hFFFF40F8) begin failures++; $display("FAIL v7_digits: got %h expected ffff40f8", segs); end
    apply_and_capture(14'd105, segs, ovf, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL v105_timeout: frame alignment not found"); end
    if (segs !== 32'hFFF94092) begin failures++; $display("FAIL v105_digits: got %h expected fff94092", segs); end
  endtask

  task automatic test_overflow;
    logic [31:0] segs;
    logic        ovf;
    logic        ok;
    apply_and_capture(14'd10000, segs, ovf, ok);
    checks += 3;
    if (!ok) begin failures++; $display("FAIL v10000_timeout: frame alignment not found"); end
    if (segs !== 32'h90901090) begin failures++; $display("FAIL v10000_digits: got %h expected 90901090", segs); end
    if (ovf !== 1'b1) begin failures++; $display("FAIL v10000_ovf: got %b expected 1", ovf); end
    apply_and_capture(14'd16383, segs, ovf, ok);
    checks += 2;
    if (segs !== 32'h90901090) begin failures++; $display("FAIL v16383_digits: got %h expected 90901090", segs); end
    if (ovf !== 1'b1) begin failures++; $display("FAIL v16383_ovf: got %b expected 1", ovf); end
    apply_and_capture(14'd42, segs, ovf, ok);
    checks += 2;
    if (segs !== 32'hFFFF19A4) begin failures++; $display("FAIL v42_digits: got %h expected ffff19a4", segs); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL v42_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_toggle_during_shift;
    logic [31:0] segs;
    logic        ovf;
    logic        ok;
    value = 14'd1111;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          value = (value == 14'd1111) ? 14'd2222 : 14'd1111;
        end
      end
      begin
        repeat (41) @(negedge clk);
        capture(segs, ovf, ok);
      end
    join
    checks += 2;
    if (!ok) begin failures++; $display("FAIL toggle_timeout: frame alignment not found"); end
    if (segs !== 32'hF9F979F9 && segs !== 32'hA4A424A4)
      begin failures++; $display("FAIL toggle_consistent: got %h expected f9f979f9 or a4a424a4", segs); end
  endtask

  task automatic test_blank;
    int bad = 0;
    logic [3:0] exp_sel;
    value = 14'd1234;
    @(negedge clk);
    blank = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (seg !== 8'hFF || sel !== 4'hF) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL blank_dark: %0d samples lit, expected 0", bad); end
    blank = 1'b0;
    @(negedge clk);
    exp_sel = ~(4'b0001 << (((cyc - 1) / 10) % 4));
    checks++;
    if (sel !== exp_sel) begin failures++; $display("FAIL blank_resume_sel: got %h expected %h", sel, exp_sel); end
  endtask

  task automatic test_reset_mid_conversion;
    logic [31:0] segs;
    logic        ovf;
    logic        ok;
    int          guard = 0;
    apply_and_capture(14'd16383, segs, ovf, ok);
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("FAIL pre_reset_ovf: got %b expected 1", ovf); end
    while ((cyc % 40) != 8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    #3 rst = 1'b1;
    #1;
    checks += 3;
    if (seg !== 8'hFF) begin failures++; $display("FAIL async_rst_seg: got %h expected ff", seg); end
    if (sel !== 4'hF) begin failures++; $display("FAIL async_rst_sel: got %h expected f", sel); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL async_rst_ovf: got %b expected 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 57; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          checks += 2;
          if (sel !== 4'hE) begin failures++; $display("FAIL rst2_first_sel: got %h expected e", sel); end
          if (seg !== 8'hC0) begin failures++; $display("FAIL rst2_first_seg: got %h expected c0", seg); end
        end
        11: begin
          checks++;
          if (seg !== 8'h40) begin failures++; $display("FAIL rst2_no_partial: got %h expected 40", seg); end
        end
        57: begin
          checks += 2;
          if (seg !== 8'h10) begin failures++; $display("FAIL rst2_reconvert: got %h expected 10", seg); end
          if (overflow !== 1'b1) begin failures++; $display("FAIL rst2_ovf: got %b expected 1", overflow); end
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_small_values();
    test_overflow();
    test_toggle_during_shift();
    test_blank();
    test_reset_mid_conversion();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
